// File: rtl/jt900h_div.sv
// Iterative restoring divider for DIV/DIVS (byte 16/8, word 32/16), unsigned and signed.
// Results go out through dout with a one-cycle width strobe on we; overflow is flagged on v.
module jt900h_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        start,
  input  logic        sgn,
  input  logic [2:0]  w,
  input  logic [31:0] op0,
  input  logic [15:0] op1,
  output logic        busy,
  output logic        done,
  output logic [2:0]  we,
  output logic        v,
  output logic [31:0] dout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [2:0]  w_r;
  logic        sgn_r;
  logic [31:0] op0_r;
  logic [15:0] op1_r;
  logic [15:0] div_r, rem_r, quo_r;
  logic [3:0]  cnt_r;
  logic        dd_neg_r, dv_neg_r, ovf_r;
  logic        busy_r, done_r, v_r;
  logic [2:0]  we_r;
  logic [31:0] dout_r;

  logic        go_s, byte_s;
  logic        dd_neg_s, dv_neg_s, pre_ovf_s;
  logic [31:0] dd_mag_s;
  logic [15:0] dv_mag_s, hi_s, lo_s;
  logic        msb_s, borrow_s;
  logic [16:0] shl_s;
  logic [17:0] trial_s;
  logic        q_neg_s, rng_ovf_s, fix_ovf_s;
  logic [15:0] quo_mag_s, rem_mag_s, q_out_s, r_out_s, lim_s;
  logic [31:0] res_s;

  assign go_s   = start & (w[1:0] != 2'b00);
  assign byte_s = w_r[0];

  // State register, frozen while cen is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else if (cen) begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (go_s) state_nxt_s = PREP;
        else      state_nxt_s = IDLE;
      end
      PREP: begin
        if (pre_ovf_s) state_nxt_s = FIX;
        else           state_nxt_s = CALC;
      end
      CALC: begin
        if (cnt_r == 4'd0) state_nxt_s = FIX;
        else               state_nxt_s = CALC;
      end
      FIX:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand magnitudes, signs and the early overflow precheck
  always_comb begin
    dd_neg_s = 1'b0;
    dv_neg_s = 1'b0;
    dd_mag_s = 32'd0;
    dv_mag_s = 16'd0;
    hi_s     = 16'd0;
    lo_s     = 16'd0;
    if (byte_s) begin
      dd_neg_s = sgn_r & op0_r[15];
      dv_neg_s = sgn_r & op1_r[7];
      dd_mag_s = dd_neg_s ? {16'd0, 16'd0 - op0_r[15:0]} : {16'd0, op0_r[15:0]};
      dv_mag_s = dv_neg_s ? {8'd0, 8'd0 - op1_r[7:0]} : {8'd0, op1_r[7:0]};
      hi_s     = {8'd0, dd_mag_s[15:8]};
      lo_s     = {8'd0, dd_mag_s[7:0]};
    end else begin
      dd_neg_s = sgn_r & op0_r[31];
      dv_neg_s = sgn_r & op1_r[15];
      dd_mag_s = dd_neg_s ? 32'd0 - op0_r : op0_r;
      dv_mag_s = dv_neg_s ? 16'd0 - op1_r : op1_r;
      hi_s     = dd_mag_s[31:16];
      lo_s     = dd_mag_s[15:0];
    end
    pre_ovf_s = (dv_mag_s == 16'd0) | (hi_s >= dv_mag_s);
  end

  // One restoring step; rem < div keeps a non-borrowing trial within 16 bits,
  // so bit 16 can only be set together with the borrow bit
  always_comb begin
    msb_s    = byte_s ? quo_r[7] : quo_r[15];
    shl_s    = {rem_r, msb_s};
    trial_s  = {1'b0, shl_s} - {2'b00, div_r};
    borrow_s = trial_s[17] | trial_s[16];
  end

  // Sign fix-up, signed range check and write-back value
  always_comb begin
    quo_mag_s = byte_s ? {8'd0, quo_r[7:0]} : quo_r;
    rem_mag_s = byte_s ? {8'd0, rem_r[7:0]} : rem_r;
    q_neg_s   = dd_neg_r ^ dv_neg_r;
    lim_s     = byte_s ? 16'h0080 : 16'h8000;
    rng_ovf_s = sgn_r & (q_neg_s ? (quo_mag_s > lim_s) : (quo_mag_s >= lim_s));
    fix_ovf_s = ovf_r | rng_ovf_s;
    q_out_s   = q_neg_s  ? 16'd0 - quo_mag_s : quo_mag_s;
    r_out_s   = dd_neg_r ? 16'd0 - rem_mag_s : rem_mag_s;
    if (fix_ovf_s) begin
      res_s = byte_s ? {16'd0, op0_r[15:0]} : op0_r;
    end else if (byte_s) begin
      res_s = {16'd0, r_out_s[7:0], q_out_s[7:0]};
    end else begin
      res_s = {r_out_s, q_out_s};
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_r      <= 3'd0;
      sgn_r    <= 1'b0;
      op0_r    <= 32'd0;
      op1_r    <= 16'd0;
      div_r    <= 16'd0;
      rem_r    <= 16'd0;
      quo_r    <= 16'd0;
      cnt_r    <= 4'd0;
      dd_neg_r <= 1'b0;
      dv_neg_r <= 1'b0;
      ovf_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      we_r     <= 3'd0;
      v_r      <= 1'b0;
      dout_r   <= 32'd0;
    end else if (cen) begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          we_r   <= 3'd0;
          if (go_s) begin
            w_r    <= w;
            sgn_r  <= sgn;
            op0_r  <= op0;
            op1_r  <= op1;
            busy_r <= 1'b1;
          end
        end
        PREP: begin
          dd_neg_r <= dd_neg_s;
          dv_neg_r <= dv_neg_s;
          div_r    <= dv_mag_s;
          rem_r    <= hi_s;
          quo_r    <= lo_s;
          ovf_r    <= pre_ovf_s;
          cnt_r    <= byte_s ? 4'd7 : 4'd15;
        end
        CALC: begin
          cnt_r <= cnt_r - 4'd1;
          quo_r <= {quo_r[14:0], ~borrow_s};
          rem_r <= borrow_s ? shl_s[15:0] : trial_s[15:0];
        end
        FIX: begin
          dout_r <= res_s;
          v_r    <= fix_ovf_s;
          done_r <= 1'b1;
          we_r   <= w_r;
          busy_r <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign we   = we_r;
  assign v    = v_r;
  assign dout = dout_r;

endmodule

// File: tb/tb_jt900h_div.sv
// Self-checking bench for jt900h_div: directed vectors plus randomized operations
// checked against an arithmetic reference model.
module tb_jt900h_div;

  logic        clk = 1'b0;
  logic        rst_n, cen, start, sgn;
  logic [2:0]  w;
  logic [31:0] op0;
  logic [15:0] op1;
  logic        busy, done, v;
  logic [2:0]  we;
  logic [31:0] dout;

  int checks = 0;
  int failures = 0;

  jt900h_div dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .start(start), .sgn(sgn), .w(w),
    .op0(op0), .op1(op1), .busy(busy), .done(done), .we(we), .v(v), .dout(dout)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division with the range rules of DIV/DIVS
  task automatic model(input logic sg, input logic [2:0] ww, input logic [31:0] a,
                       input logic [15:0] b, output logic [31:0] d, output logic vv,
                       output int lat);
    int n;
    longint x, y, q, r, ax, ay;
    n = ww[0] ? 8 : 16;
    if (ww[0]) begin
      x = sg ? longint'($signed(a[15:0])) : longint'(a[15:0]);
      y = sg ? longint'($signed(b[7:0]))  : longint'(b[7:0]);
    end else begin
      x = sg ? longint'($signed(a)) : longint'(a);
      y = sg ? longint'($signed(b)) : longint'(b);
    end
    lat = n + 2;
    vv  = 1'b0;
    q   = 0;
    r   = 0;
    if (y == 0) begin
      vv  = 1'b1;
      lat = 2;
    end else begin
      ax = (x < 0) ? -x : x;
      ay = (y < 0) ? -y : y;
      if (ax / ay >= (longint'(1) << n)) begin
        vv  = 1'b1;
        lat = 2;
      end
      q = x / y;
      r = x % y;
      if (sg && (q > (longint'(1) << (n - 1)) - 1 || q < -(longint'(1) << (n - 1)))) vv = 1'b1;
    end
    if (vv) d = ww[0] ? {16'd0, a[15:0]} : a;
    else    d = ww[0] ? {16'd0, r[7:0], q[7:0]} : {r[15:0], q[15:0]};
  endtask

  // Issue one division and wait (bounded) for done; returns at #1 after the done edge
  task automatic do_div(input logic sg, input logic [2:0] ww, input logic [31:0] a,
                        input logic [15:0] b, output int lat, output logic [31:0] d,
                        output logic vv, output logic [2:0] wee);
    sgn = sg; w = ww; op0 = a; op1 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; sgn = ~sg; op0 = ~a; op1 = ~b; w = ~ww;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL start_ack busy=%b done=%b required busy=1 done=0", busy, done);
    end
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    d = dout; vv = v; wee = we;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cen = 1'b1; start = 1'b0; sgn = 1'b0; w = 3'd0; op0 = 32'd0; op1 = 16'd0;
    #22;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || we !== 3'd0 || v !== 1'b0 || dout !== 32'd0) begin
      failures++;
      $display("FAIL reset busy=%b done=%b we=%b v=%b dout=%h required all zero", busy, done, we, v, dout);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic        t_sg  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0]  t_w   [7] = '{3'b001, 3'b010, 3'b001, 3'b001, 3'b001, 3'b001, 3'b010};
    logic [31:0] t_a   [7] = '{32'h0000_0064, 32'h0001_86A0, 32'h0000_1234, 32'h0000_1000,
                               32'h0000_FFF9, 32'h0000_0080, 32'hFFFE_7960};
    logic [15:0] t_b   [7] = '{16'h0007, 16'h0064, 16'h0000, 16'h0010, 16'h0002, 16'h0001, 16'h0007};
    logic [31:0] t_d   [7] = '{32'h0000_020E, 32'h0000_03E8, 32'h0000_1234, 32'h0000_1000,
                               32'h0000_FFFD, 32'h0000_0080, 32'hFFFB_C833};
    logic        t_v   [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    int          t_lat [7] = '{10, 18, 2, 2, 10, 10, 18};
    int lat;
    logic [31:0] d;
    logic vv;
    logic [2:0] wee;
    for (int k = 0; k < 7; k++) begin
      do_div(t_sg[k], t_w[k], t_a[k], t_b[k], lat, d, vv, wee);
      checks++;
      if (lat != t_lat[k] || d !== t_d[k] || vv !== t_v[k] || wee !== t_w[k]) begin
        failures++;
        $display("FAIL directed_%0d lat=%0d dout=%h v=%b we=%b required lat=%0d dout=%h v=%b we=%b",
                 k, lat, d, vv, wee, t_lat[k], t_d[k], t_v[k], t_w[k]);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || we !== 3'd0 || v !== t_v[k] || dout !== t_d[k] || busy !== 1'b0) begin
        failures++;
        $display("FAIL done_drop_%0d done=%b we=%b v=%b dout=%h busy=%b required 0,0,%b,%h,0",
                 k, done, we, v, dout, busy, t_v[k], t_d[k]);
      end
    end
  endtask

  task automatic test_random;
    logic sg;
    logic [2:0] ww;
    logic [31:0] a, d, ed;
    logic [15:0] b;
    logic vv, ev;
    logic [2:0] wee;
    int lat, elat;
    for (int k = 0; k < 60; k++) begin
      sg = 1'($urandom_range(0, 1));
      ww = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b010;
      b  = 16'($urandom);
      if ($urandom_range(0, 9) == 0) b = 16'd0;
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a >> $urandom_range(8, 24);
      if (sg && $urandom_range(0, 1) == 1) a = 32'd0 - a;
      model(sg, ww, a, b, ed, ev, elat);
      do_div(sg, ww, a, b, lat, d, vv, wee);
      checks++;
      if (lat != elat || d !== ed || vv !== ev || wee !== ww) begin
        failures++;
        $display("FAIL random_%0d sgn=%b w=%b op0=%h op1=%h got lat=%0d dout=%h v=%b we=%b required lat=%0d dout=%h v=%b",
                 k, sg, ww, a, b, lat, d, vv, wee, elat, ed, ev);
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [31:0] d;
    logic vv;
    logic [2:0] wee;
    do_div(1'b0, 3'b001, 32'h0000_0064, 16'h0007, lat, d, vv, wee);
    do_div(1'b0, 3'b010, 32'h0001_86A0, 16'h0064, lat, d, vv, wee);
    checks++;
    if (lat != 18 || d !== 32'h0000_03E8 || vv !== 1'b0 || wee !== 3'b010) begin
      failures++;
      $display("FAIL back_to_back lat=%0d dout=%h v=%b we=%b required 18 000003e8 0 010", lat, d, vv, wee);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored;
    int ndone, first;
    logic [31:0] d;
    sgn = 1'b0; w = 3'b010; op0 = 32'h0001_86A0; op1 = 16'h0064; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; first = -1; d = 32'd0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) begin
          first = i;
          d = dout;
        end
      end
      start = 1'b0;
      if (i == 3) begin
        w = 3'b001; op0 = 32'h0000_1234; op1 = 16'h0000; start = 1'b1;
      end
    end
    checks++;
    if (ndone != 1 || first != 18 || d !== 32'h0000_03E8) begin
      failures++;
      $display("FAIL start_ignored dones=%0d lat=%0d dout=%h required 1 18 000003e8", ndone, first, d);
    end
  endtask

  task automatic test_w_zero;
    int ndone;
    sgn = 1'b0; w = 3'b100; op0 = 32'h0000_0064; op1 = 16'h0007; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL w_zero_busy busy=%b required 0", busy);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      failures++;
      $display("FAIL w_zero_done dones=%0d required 0", ndone);
    end
  endtask

  task automatic test_cen_stall;
    int first;
    logic [31:0] d;
    sgn = 1'b0; w = 3'b010; op0 = 32'h0001_86A0; op1 = 16'h0064; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    first = -1; d = 32'd0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 && first < 0) begin
        first = i;
        d = dout;
      end
      if (i == 4) cen = 1'b0;
      if (i == 9) cen = 1'b1;
      if (first > 0) break;
    end
    cen = 1'b1;
    checks++;
    if (first != 23 || d !== 32'h0000_03E8) begin
      failures++;
      $display("FAIL cen_stall lat=%0d dout=%h required 23 000003e8", first, d);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort;
    int lat;
    logic [31:0] d;
    logic vv;
    logic [2:0] wee;
    do_div(1'b0, 3'b001, 32'h0000_1234, 16'h0000, lat, d, vv, wee);
    @(posedge clk); #1;
    sgn = 1'b0; w = 3'b010; op0 = 32'h0001_86A0; op1 = 16'h0064; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || v !== 1'b0 || dout !== 32'd0 || we !== 3'd0) begin
      failures++;
      $display("FAIL reset_abort busy=%b done=%b v=%b dout=%h we=%b required all zero", busy, done, v, dout, we);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    do_div(1'b0, 3'b010, 32'h0001_86A0, 16'h0064, lat, d, vv, wee);
    checks++;
    if (lat != 18 || d !== 32'h0000_03E8 || vv !== 1'b0 || wee !== 3'b010) begin
      failures++;
      $display("FAIL after_reset lat=%0d dout=%h v=%b we=%b required 18 000003e8 0 010", lat, d, vv, wee);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_start_ignored;
    test_w_zero;
    test_cen_stall;
    test_reset_abort;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
